// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - stall bit indices, stall encodings and FSM states for pipeline_ctrl
`ifndef CPU_IADDR_W
`define CPU_IADDR_W 32
`endif

package pipeline_ctrl_pkg;

  // Instruction-address bus width shared with the rest of the core.
  localparam int IADDR_W = `CPU_IADDR_W;

  // Stall vector bit positions, one per pipeline register.
  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  // A stalling stage freezes itself and everything upstream; the register
  // just downstream of it sees no stall and therefore takes a bubble.
  localparam logic [5:0] STALL_ENC_IF  = (6'd1 << STALL_PC) | (6'd1 << STALL_IF_ID);
  localparam logic [5:0] STALL_ENC_ID  = STALL_ENC_IF | (6'd1 << STALL_ID_EX);
  localparam logic [5:0] STALL_ENC_EX  = STALL_ENC_ID | (6'd1 << STALL_EX_MEM);
  localparam logic [5:0] STALL_ENC_MEM = STALL_ENC_EX | (6'd1 << STALL_MEM_WB);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/exception/redirect signal bundle between datapath and pipeline_ctrl
interface pipeline_ctrl_if;

  logic                                  stallreq_if;
  logic                                  stallreq_id;
  logic                                  stallreq_ex;
  logic                                  stallreq_mem;
  logic                                  excp_valid;
  logic [pipeline_ctrl_pkg::IADDR_W-1:0] excp_pc;
  logic                                  wdog_clr;

  logic [5:0]                            stall;
  logic                                  flush;
  logic [pipeline_ctrl_pkg::IADDR_W-1:0] new_pc;
  logic                                  new_pc_valid;
  logic                                  busy;
  logic                                  stall_timeout;

  // Datapath side: raises requests, consumes stall/flush/redirect.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_pc, wdog_clr,
    input  stall, flush, new_pc, new_pc_valid, busy, stall_timeout
  );

  // Controller side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_pc, wdog_clr,
    output stall, flush, new_pc, new_pc_valid, busy, stall_timeout
  );

endinterface

// File: rtl/pipeline_ctrl_wdog.sv
// rtl/pipeline_ctrl_wdog.sv - saturating stuck-stall counter with sticky timeout flag
module pipeline_ctrl_wdog #(
  parameter int LIMIT = 1024,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic stalled,
  input  logic restart,
  input  logic clr,
  output logic timeout
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic         timeout_next;

  // Clear beats a restart, a restart beats counting; any unstalled RUN cycle breaks the run.
  always_comb begin
    cnt_next     = cnt;
    timeout_next = timeout;
    if (clr) begin
      cnt_next     = '0;
      timeout_next = 1'b0;
    end else begin
      if (restart) begin
        cnt_next = '0;
      end else if (stalled) begin
        cnt_next = (cnt == LIMIT_V) ? cnt : cnt + 1'b1;
      end else if (run) begin
        cnt_next = '0;
      end
      if (cnt_next == LIMIT_V) begin
        timeout_next = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      timeout <= timeout_next;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush/redirect sequencer; PIPELINE_CTRL_PERF_EN adds stall-source counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1024,
  parameter int WDOG_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       intf
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_if,
  output logic [31:0]          perf_stall_id,
  output logic [31:0]          perf_stall_ex,
  output logic [31:0]          perf_stall_mem
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e             state;
  state_e             state_next;
  logic [3:0]         fcnt;
  logic [3:0]         fcnt_next;
  logic [IADDR_W-1:0] new_pc_q;
  logic [IADDR_W-1:0] new_pc_next;
  logic [5:0]         stall_raw;
  logic               run;

  assign run = (state == ST_RUN);

  // Highest (most downstream) requesting stage decides how far the freeze reaches.
  always_comb begin
    stall_raw = '0;
    if (intf.stallreq_mem) begin
      stall_raw = STALL_ENC_MEM;
    end else if (intf.stallreq_ex) begin
      stall_raw = STALL_ENC_EX;
    end else if (intf.stallreq_id) begin
      stall_raw = STALL_ENC_ID;
    end else if (intf.stallreq_if) begin
      stall_raw = STALL_ENC_IF;
    end
  end

  // State, flush counter and redirect target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      fcnt     <= '0;
      new_pc_q <= '0;
    end else begin
      state    <= state_next;
      fcnt     <= fcnt_next;
      new_pc_q <= new_pc_next;
    end
  end

  // Only RUN accepts an exception, so the first one wins until the redirect is issued.
  always_comb begin
    state_next  = state;
    fcnt_next   = fcnt;
    new_pc_next = new_pc_q;
    case (state)
      ST_RUN: begin
        if (intf.excp_valid) begin
          new_pc_next = intf.excp_pc;
          fcnt_next   = FLUSH_LOAD;
          state_next  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fcnt <= 4'd1) begin
          fcnt_next  = '0;
          state_next = ST_REDIRECT;
        end else begin
          fcnt_next = fcnt - 4'd1;
        end
      end
      ST_REDIRECT: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign intf.stall        = run ? stall_raw : 6'd0;
  assign intf.flush        = (state == ST_FLUSH);
  assign intf.new_pc_valid = (state == ST_REDIRECT);
  assign intf.busy         = !run;
  assign intf.new_pc       = new_pc_q;

  pipeline_ctrl_wdog #(
    .LIMIT (WDOG_LIMIT),
    .W     (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .stalled (run && (stall_raw != 6'd0)),
    .restart (run && intf.excp_valid),
    .clr     (intf.wdog_clr),
    .timeout (intf.stall_timeout)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  // Credit each RUN cycle to the stage that won stall arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_if  <= '0;
      perf_stall_id  <= '0;
      perf_stall_ex  <= '0;
      perf_stall_mem <= '0;
    end else if (run) begin
      if (intf.stallreq_mem) begin
        perf_stall_mem <= perf_stall_mem + 32'd1;
      end else if (intf.stallreq_ex) begin
        perf_stall_ex <= perf_stall_ex + 32'd1;
      end else if (intf.stallreq_id) begin
        perf_stall_id <= perf_stall_id + 32'd1;
      end else if (intf.stallreq_if) begin
        perf_stall_if <= perf_stall_if + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl (two flush lengths, shared stimulus)
module tb_pipeline_ctrl;

  localparam int F_A = 1;
  localparam int F_B = 3;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if ifa();
  pipeline_ctrl_if ifb();

  assign ifb.stallreq_if  = ifa.stallreq_if;
  assign ifb.stallreq_id  = ifa.stallreq_id;
  assign ifb.stallreq_ex  = ifa.stallreq_ex;
  assign ifb.stallreq_mem = ifa.stallreq_mem;
  assign ifb.excp_valid   = ifa.excp_valid;
  assign ifb.excp_pc      = ifa.excp_pc;
  assign ifb.wdog_clr     = ifa.wdog_clr;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] pa_if, pa_id, pa_ex, pa_mem, pb_if, pb_id, pb_ex, pb_mem;
`endif

  pipeline_ctrl #(.FLUSH_CYCLES(F_A), .WDOG_LIMIT(LIM), .WDOG_W(16)) dut_a (
    .clk (clk),
    .rst (rst_n),
    .intf(ifa)
`ifdef PIPELINE_CTRL_PERF_EN
    , .perf_stall_if(pa_if), .perf_stall_id(pa_id), .perf_stall_ex(pa_ex), .perf_stall_mem(pa_mem)
`endif
  );

  pipeline_ctrl #(.FLUSH_CYCLES(F_B), .WDOG_LIMIT(LIM), .WDOG_W(16)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .intf(ifb)
`ifdef PIPELINE_CTRL_PERF_EN
    , .perf_stall_if(pb_if), .perf_stall_id(pb_id), .perf_stall_ex(pb_ex), .perf_stall_mem(pb_mem)
`endif
  );

  // Reference model: k = cycles since an accepted exception (0 = running normally).
  int          k   [2];
  logic [31:0] mpc [2];
  int          wc  [2];
  bit          wto [2];
  int          fc  [2] = '{F_A, F_B};

  function automatic int winner(bit i, bit d, bit e, bit m);
    return m ? 4 : e ? 3 : d ? 2 : i ? 1 : 0;
  endfunction

  function automatic logic [5:0] enc(int w);
    return (w == 0) ? 6'd0 : 6'((1 << (w + 1)) - 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        k[d] = 0; mpc[d] = '0; wc[d] = 0; wto[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int  w;
        bit  running;
        w = winner(ifa.stallreq_if, ifa.stallreq_id, ifa.stallreq_ex, ifa.stallreq_mem);
        running = (k[d] == 0);
        if (ifa.wdog_clr) begin
          wc[d] = 0; wto[d] = 1'b0;
        end else if (running && ifa.excp_valid) begin
          wc[d] = 0;
        end else if (running && w > 0) begin
          if (wc[d] < LIM) wc[d] = wc[d] + 1;
          if (wc[d] == LIM) wto[d] = 1'b1;
        end else if (running) begin
          wc[d] = 0;
        end
        if (running) begin
          if (ifa.excp_valid) begin
            k[d] = 1; mpc[d] = ifa.excp_pc;
          end
        end else if (k[d] == fc[d] + 1) begin
          k[d] = 0;
        end else begin
          k[d] = k[d] + 1;
        end
      end
    end
  end

  task automatic cmp_one(int d, string tag, logic [5:0] st, logic fl, logic [31:0] np,
                         logic npv, logic bz, logic to);
    int w;
    w = winner(ifa.stallreq_if, ifa.stallreq_id, ifa.stallreq_ex, ifa.stallreq_mem);
    chk({tag, "_stall"},   st,  (k[d] == 0) ? enc(w) : 6'd0);
    chk({tag, "_flush"},   fl,  (k[d] >= 1) && (k[d] <= fc[d]));
    chk({tag, "_new_pc"},  np,  mpc[d]);
    chk({tag, "_npv"},     npv, k[d] == fc[d] + 1);
    chk({tag, "_busy"},    bz,  k[d] != 0);
    chk({tag, "_timeout"}, to,  wto[d]);
  endtask

  always @(negedge clk) begin
    cmp_one(0, "a", ifa.stall, ifa.flush, ifa.new_pc, ifa.new_pc_valid, ifa.busy, ifa.stall_timeout);
    cmp_one(1, "b", ifb.stall, ifb.flush, ifb.new_pc, ifb.new_pc_valid, ifb.busy, ifb.stall_timeout);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npv;
    int storm;
    ifa.stallreq_if = 0; ifa.stallreq_id = 0; ifa.stallreq_ex = 0; ifa.stallreq_mem = 0;
    ifa.excp_valid = 0; ifa.excp_pc = '0; ifa.wdog_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_stall", ifa.stall, 6'd0);
    chk("rst_new_pc", ifb.new_pc, 32'h0);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_timeout", ifb.stall_timeout, 1'b0);

    // stall priority
    ifa.stallreq_id = 1; #1;
    chk("prio_id", ifa.stall, 6'b000111);
    ifa.stallreq_mem = 1; #1;
    chk("prio_id_mem", ifa.stall, 6'b011111);
    step();
    ifa.stallreq_id = 0; ifa.stallreq_mem = 0; #1;
    chk("prio_release", ifa.stall, 6'b000000);
    step();

    // exception redirect, one flush cycle on a
    ifa.excp_valid = 1; ifa.excp_pc = 32'hBFC00380;
    step();
    ifa.excp_valid = 0;
    chk("x1_flush_n1", ifa.flush, 1'b1);
    chk("x1_busy_n1", ifa.busy, 1'b1);
    chk("x1_npv_n1", ifa.new_pc_valid, 1'b0);
    step();
    chk("x1_flush_n2", ifa.flush, 1'b0);
    chk("x1_npv_n2", ifa.new_pc_valid, 1'b1);
    chk("x1_new_pc", ifa.new_pc, 32'hBFC00380);
    chk("x1_busy_n2", ifa.busy, 1'b1);
    step();
    chk("x1_busy_n3", ifa.busy, 1'b0);
    chk("x1_flush_b_n3", ifb.flush, 1'b1);
    repeat (3) step();

    // exception together with an execute stall
    ifa.stallreq_ex = 1; ifa.excp_valid = 1; ifa.excp_pc = 32'h8000_0000; #1;
    chk("xs_same_cycle", ifa.stall, 6'b001111);
    step();
    ifa.excp_valid = 0;
    chk("xs_a_n1", ifa.stall, 6'd0);
    chk("xs_b_n1", ifb.stall, 6'd0);
    step();
    chk("xs_a_n2", ifa.stall, 6'd0);
    step();
    chk("xs_a_n3", ifa.stall, 6'b001111);
    chk("xs_b_n3", ifb.stall, 6'd0);
    step(); step();
    chk("xs_b_n5", ifb.stall, 6'b001111);
    ifa.stallreq_ex = 0;
    repeat (2) step();

    // second exception during flush keeps the first target
    ifa.excp_valid = 1; ifa.excp_pc = 32'h8000_0180;
    step();
    ifa.excp_pc = 32'hDEADBEE0;
    step();
    ifa.excp_valid = 0;
    npv = 0;
    repeat (6) begin
      npv += int'(ifb.new_pc_valid);
      step();
    end
    chk("x2_b_npv_pulses", npv, 1);
    chk("x2_b_new_pc", ifb.new_pc, 32'h8000_0180);
    chk("x2_a_new_pc", ifa.new_pc, 32'h8000_0180);

    // watchdog
    ifa.wdog_clr = 1; step(); ifa.wdog_clr = 0; step();
    ifa.stallreq_mem = 1;
    repeat (7) step();
    chk("wd_7", ifa.stall_timeout, 1'b0);
    step();
    chk("wd_8_a", ifa.stall_timeout, 1'b1);
    chk("wd_8_b", ifb.stall_timeout, 1'b1);
    ifa.stallreq_mem = 0;
    step(); step();
    chk("wd_sticky", ifa.stall_timeout, 1'b1);
    ifa.wdog_clr = 1; step(); ifa.wdog_clr = 0;
    chk("wd_clr", ifa.stall_timeout, 1'b0);
    ifa.stallreq_mem = 1;
    repeat (7) step();
    ifa.stallreq_mem = 0;
    repeat (3) step();
    chk("wd_held7", ifa.stall_timeout, 1'b0);

    // asynchronous reset in the middle of a flush
    ifa.excp_valid = 1; ifa.excp_pc = 32'h1234_5670;
    step();
    ifa.excp_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flush_b", ifb.flush, 1'b0);
    chk("ar_busy_b", ifb.busy, 1'b0);
    chk("ar_npv_a", ifa.new_pc_valid, 1'b0);
    chk("ar_new_pc_b", ifb.new_pc, 32'h0);
    step(); step();
    rst_n = 1'b1;
    npv = 0;
    repeat (6) begin
      step();
      npv += int'(ifa.new_pc_valid) + int'(ifb.new_pc_valid);
    end
    chk("ar_no_redirect", npv, 0);

    // randomized traffic, checked every cycle by the model comparison
    storm = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) storm = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rst_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      ifa.stallreq_if  = ($urandom_range(0, 3) == 0);
      ifa.stallreq_id  = ($urandom_range(0, 3) == 0);
      ifa.stallreq_ex  = ($urandom_range(0, 4) == 0);
      ifa.stallreq_mem = storm ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 5) == 0);
      ifa.excp_valid   = ($urandom_range(0, 15) == 0);
      ifa.excp_pc      = $urandom;
      ifa.wdog_clr     = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
